pcie_tx_arbiter: RTL and testbench

- Shares the PCIe endpoint AXI-stream TX port (s_axis_tx_*) between NUM_REQ TLP sources, e.g. completion engine, DMA write engine and message generator.
- Arbitration is round-robin at packet granularity: a granted source owns the port until its tlast beat.
- Grants are gated on link-up and on transmit-buffer availability (tx_buf_av).
- Services the core's configuration-TLP handshake (tx_cfg_req/tx_cfg_gnt) between packets, and counts tx_err_drop events.

---
 rtl/pcie_tx_arbiter_pkg.sv | 20 ++
 rtl/pcie_tx_arbiter_if.sv | 42 ++++
 rtl/rr_priority_select.sv | 35 +++
 rtl/pcie_tx_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_pcie_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_tx_arbiter_pkg.sv
// Shared definitions for the PCIe TX arbiter slice.
// Contents: arbiter state encoding and AXI-stream field widths of the
// 32-bit endpoint TX interface.
package pcie_tx_arb_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] CFG  = 2'd2;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_KEEP_W = 4;
  localparam int AXIS_USER_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_XFER = XFER,
    ST_CFG  = CFG
  } arb_state_e;

endpackage

// File: rtl/pcie_tx_arbiter_if.sv
// Stream bundle between the TLP sources, the arbiter and the PCIe core TX port.
// Requester side : i_req_tdata/tkeep/tuser/tlast/tvalid (packed, requester k
//                  in slice k), o_req_tready (one bit per requester).
// Core side      : s_axis_tx_tdata/tkeep/tuser/tlast/tvalid, s_axis_tx_tready.
// Modports: slave = arbiter view, master = view of the surrounding logic
// (sources plus core).
interface pcie_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  import pcie_tx_arb_pkg::*;

  logic [NUM_REQ*AXIS_DATA_W-1:0] i_req_tdata;
  logic [NUM_REQ*AXIS_KEEP_W-1:0] i_req_tkeep;
  logic [NUM_REQ*AXIS_USER_W-1:0] i_req_tuser;
  logic [NUM_REQ-1:0]             i_req_tlast;
  logic [NUM_REQ-1:0]             i_req_tvalid;
  logic [NUM_REQ-1:0]             o_req_tready;

  logic [AXIS_DATA_W-1:0]         s_axis_tx_tdata;
  logic [AXIS_KEEP_W-1:0]         s_axis_tx_tkeep;
  logic [AXIS_USER_W-1:0]         s_axis_tx_tuser;
  logic                           s_axis_tx_tlast;
  logic                           s_axis_tx_tvalid;
  logic                           s_axis_tx_tready;

  modport slave (
    input  i_req_tdata, i_req_tkeep, i_req_tuser, i_req_tlast, i_req_tvalid,
    output o_req_tready,
    output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser,
    output s_axis_tx_tlast, s_axis_tx_tvalid,
    input  s_axis_tx_tready
  );

  modport master (
    output i_req_tdata, i_req_tkeep, i_req_tuser, i_req_tlast, i_req_tvalid,
    input  o_req_tready,
    input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser,
    input  s_axis_tx_tlast, s_axis_tx_tvalid,
    output s_axis_tx_tready
  );

endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector.
// Searches valid[last+1], valid[last+2], ... (mod N) and returns the first
// hit as a one-hot grant plus its binary index.
// Ports: valid (N requests), last (index of previous winner),
//        grant (one-hot, 0 if nothing valid), idx (winner index), found.
module rr_priority_select #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // i runs to N so the previous winner is considered last.
    for (int i = 1; i <= N; i++) begin
      cand = (int'(last) + i) % N;
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the PCIe endpoint TX port
// between NUM_REQ TLP sources, with config-TLP handshake and drop counter.
// Ports:
//   clk, rst_n        user clock, synchronous active-low reset
//   user_lnk_up       link up; loss aborts an in-flight packet
//   tx_buf_av         core TX buffers; a grant needs >= MIN_BUF_AV
//   tx_cfg_req/gnt    core config-TLP request / grant (between packets)
//   tx_err_drop       core dropped a TLP; counted in o_drop_count
//   bus               stream bundle (slave modport)
//   o_grant           one-hot current owner
//   o_abort           one-cycle pulse when link loss cuts a packet
//   o_drop_count      saturating drop counter
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; arbitrate config request, then requesters
// XFER  | o_grant owns the TX port until its tlast beat completes
// CFG   | tx_cfg_gnt held for the core until tx_cfg_req falls
module pcie_tx_arbiter
  import pcie_tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int MIN_BUF_AV = 2,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  user_lnk_up,
  input  logic [5:0]            tx_buf_av,
  input  logic                  tx_cfg_req,
  output logic                  tx_cfg_gnt,
  input  logic                  tx_err_drop,
  pcie_tx_arbiter_if.slave      bus,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic                  o_abort,
  output logic [DROP_CNT_W-1:0] o_drop_count
);

  localparam int         IDX_W  = $clog2(NUM_REQ);
  localparam logic [5:0] MIN_AV = 6'(MIN_BUF_AV);

  arb_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic                  cfg_gnt_q, cfg_gnt_d;
  logic                  abort_q, abort_d;
  logic [DROP_CNT_W-1:0] drop_q;

  logic [NUM_REQ-1:0]    sel_grant;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_found;

  logic [AXIS_DATA_W-1:0] tx_tdata;
  logic [AXIS_KEEP_W-1:0] tx_tkeep;
  logic [AXIS_USER_W-1:0] tx_tuser;
  logic                   tx_tlast;
  logic                   tx_tvalid;
  logic                   beat_done;

  rr_priority_select #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_sel (
    .valid (bus.i_req_tvalid),
    .last  (last_q),
    .grant (sel_grant),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Data path: mux of the owner's stream, only while in XFER.
  always_comb begin
    tx_tdata  = '0;
    tx_tkeep  = '0;
    tx_tuser  = '0;
    tx_tlast  = 1'b0;
    tx_tvalid = 1'b0;
    if (state_q == ST_XFER) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant_q[k]) begin
          tx_tdata  = bus.i_req_tdata[k*AXIS_DATA_W +: AXIS_DATA_W];
          tx_tkeep  = bus.i_req_tkeep[k*AXIS_KEEP_W +: AXIS_KEEP_W];
          tx_tuser  = bus.i_req_tuser[k*AXIS_USER_W +: AXIS_USER_W];
          tx_tlast  = bus.i_req_tlast[k];
          tx_tvalid = bus.i_req_tvalid[k];
        end
      end
    end
  end

  assign beat_done = tx_tvalid && bus.s_axis_tx_tready;

  assign bus.s_axis_tx_tdata  = tx_tdata;
  assign bus.s_axis_tx_tkeep  = tx_tkeep;
  assign bus.s_axis_tx_tuser  = tx_tuser;
  assign bus.s_axis_tx_tlast  = tx_tlast;
  assign bus.s_axis_tx_tvalid = tx_tvalid;
  assign bus.o_req_tready     = (state_q == ST_XFER)
                              ? ({NUM_REQ{bus.s_axis_tx_tready}} & grant_q)
                              : '0;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cfg_gnt_d = cfg_gnt_q;
    abort_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (user_lnk_up) begin
          if (tx_cfg_req) begin
            state_d   = ST_CFG;
            cfg_gnt_d = 1'b1;
          end else if (sel_found && (tx_buf_av >= MIN_AV)) begin
            state_d = ST_XFER;
            grant_d = sel_grant;
            idx_d   = sel_idx;
          end
        end
      end
      ST_XFER: begin
        // Link loss wins over a coinciding tlast beat; either way the
        // pointer moves past the current owner.
        if (!user_lnk_up) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = idx_q;
          abort_d = 1'b1;
        end else if (beat_done && tx_tlast) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = idx_q;
        end
      end
      ST_CFG: begin
        if (!user_lnk_up || !tx_cfg_req) begin
          state_d   = ST_IDLE;
          cfg_gnt_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        grant_d   = '0;
        cfg_gnt_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      cfg_gnt_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cfg_gnt_q <= cfg_gnt_d;
      abort_q   <= abort_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (tx_err_drop && (drop_q != {DROP_CNT_W{1'b1}})) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign o_grant      = grant_q;
  assign tx_cfg_gnt   = cfg_gnt_q;
  assign o_abort      = abort_q;
  assign o_drop_count = drop_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed bench for pcie_tx_arbiter: reset, single packet, round-robin
// order, buffer threshold, config handshake, link loss, mid-packet reset
// and drop-counter saturation (second instance with a 2-bit counter).
module tb_pcie_tx_arbiter;
  import pcie_tx_arb_pkg::*;

  localparam int NUM_REQ = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               user_lnk_up;
  logic [5:0]         tx_buf_av;
  logic               tx_cfg_req;
  logic               tx_err_drop;
  logic               tx_cfg_gnt;
  logic               o_abort;
  logic [NUM_REQ-1:0] o_grant;
  logic [15:0]        o_drop_count;

  logic               sat_cfg_gnt;
  logic               sat_abort;
  logic [NUM_REQ-1:0] sat_grant;
  logic [1:0]         sat_drop_count;

  pcie_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  pcie_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_sat ();

  pcie_tx_arbiter #(.NUM_REQ(NUM_REQ), .MIN_BUF_AV(2), .DROP_CNT_W(16)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .user_lnk_up  (user_lnk_up),
    .tx_buf_av    (tx_buf_av),
    .tx_cfg_req   (tx_cfg_req),
    .tx_cfg_gnt   (tx_cfg_gnt),
    .tx_err_drop  (tx_err_drop),
    .bus          (bus),
    .o_grant      (o_grant),
    .o_abort      (o_abort),
    .o_drop_count (o_drop_count)
  );

  pcie_tx_arbiter #(.NUM_REQ(NUM_REQ), .MIN_BUF_AV(2), .DROP_CNT_W(2)) u_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .user_lnk_up  (user_lnk_up),
    .tx_buf_av    (tx_buf_av),
    .tx_cfg_req   (tx_cfg_req),
    .tx_cfg_gnt   (sat_cfg_gnt),
    .tx_err_drop  (tx_err_drop),
    .bus          (bus_sat),
    .o_grant      (sat_grant),
    .o_abort      (sat_abort),
    .o_drop_count (sat_drop_count)
  );

  int checks = 0;
  int errors = 0;

  // Source model: rem = beats left in current packet, npk = packets after it.
  int rem[NUM_REQ];
  int npk[NUM_REQ];
  int plen[NUM_REQ];
  int beat[NUM_REQ];
  int pkt_id[NUM_REQ];

  function automatic logic [31:0] exp_data(int k, int p, int b);
    return 32'hD000_0000 | (32'(k) << 16) | (32'(p) << 8) | 32'(b);
  endfunction

  task automatic drive_src();
    for (int k = 0; k < NUM_REQ; k++) begin
      bus.i_req_tvalid[k]         = (rem[k] > 0);
      bus.i_req_tlast[k]          = (rem[k] == 1);
      bus.i_req_tdata[k*32 +: 32] = exp_data(k, pkt_id[k], beat[k]);
      bus.i_req_tkeep[k*4 +: 4]   = 4'hF;
      bus.i_req_tuser[k*4 +: 4]   = 4'(k + 1);
    end
  endtask

  task automatic clear_src();
    for (int k = 0; k < NUM_REQ; k++) begin
      rem[k] = 0; npk[k] = 0; plen[k] = 0; beat[k] = 0; pkt_id[k] = 0;
    end
  endtask

  task automatic load(int k, int len, int extra);
    rem[k] = len; plen[k] = len; npk[k] = extra; beat[k] = 0;
  endtask

  // One clock: handshakes are sampled just before the edge, sources advance
  // after it, and outputs are settled when the task returns.
  task automatic tick();
    logic [NUM_REQ-1:0] hs;
    hs = bus.i_req_tvalid & bus.o_req_tready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (hs[k] && rem[k] > 0) begin
        beat[k]++;
        rem[k]--;
        if (rem[k] == 0 && npk[k] > 0) begin
          npk[k]--; rem[k] = plen[k]; beat[k] = 0; pkt_id[k]++;
        end
      end
    end
    drive_src();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; user_lnk_up = 1'b1; tx_buf_av = 6'd8;
    tx_cfg_req = 1'b0; tx_err_drop = 1'b0; bus.s_axis_tx_tready = 1'b1;
    clear_src();
    drive_src();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; user_lnk_up = 1'b1; tx_buf_av = 6'd8;
    tx_cfg_req = 1'b0; tx_err_drop = 1'b1; bus.s_axis_tx_tready = 1'b1;
    clear_src();
    load(0, 2, 0);
    drive_src();
    tick();
    tick();
    checks++; if (o_grant !== 3'b000) begin errors++; $display("FAIL reset_grant got %b exp 000", o_grant); end
    checks++; if (tx_cfg_gnt !== 1'b0) begin errors++; $display("FAIL reset_cfg_gnt got %b exp 0", tx_cfg_gnt); end
    checks++; if (o_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got %b exp 0", o_abort); end
    checks++; if (o_drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", o_drop_count); end
    checks++; if (bus.s_axis_tx_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", bus.s_axis_tx_tvalid); end
    checks++; if (bus.s_axis_tx_tdata !== 32'd0) begin errors++; $display("FAIL reset_tdata got %h exp 0", bus.s_axis_tx_tdata); end
    checks++; if (bus.o_req_tready !== 3'b000) begin errors++; $display("FAIL reset_tready got %b exp 000", bus.o_req_tready); end
    checks++; if ({sat_grant, sat_abort, sat_cfg_gnt} !== 5'd0) begin errors++; $display("FAIL reset_sat got %b exp 0", {sat_grant, sat_abort, sat_cfg_gnt}); end
    tx_err_drop = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    load(0, 4, 0);
    drive_src();
    for (int b = 0; b < 4; b++) begin
      tick();
      checks++; if (o_grant !== 3'b001) begin errors++; $display("FAIL single_grant beat %0d got %b exp 001", b, o_grant); end
      checks++; if (bus.s_axis_tx_tdata !== exp_data(0, 0, b)) begin errors++; $display("FAIL single_data beat %0d got %h exp %h", b, bus.s_axis_tx_tdata, exp_data(0, 0, b)); end
      checks++; if (bus.s_axis_tx_tlast !== (b == 3)) begin errors++; $display("FAIL single_tlast beat %0d got %b exp %b", b, bus.s_axis_tx_tlast, (b == 3)); end
      checks++; if (bus.o_req_tready !== 3'b001) begin errors++; $display("FAIL single_tready beat %0d got %b exp 001", b, bus.o_req_tready); end
      if (b == 0) begin
        checks++; if ({bus.s_axis_tx_tkeep, bus.s_axis_tx_tuser} !== 8'hF1) begin errors++; $display("FAIL single_keep_user got %h exp f1", {bus.s_axis_tx_tkeep, bus.s_axis_tx_tuser}); end
      end
    end
    tick();
    checks++; if (o_grant !== 3'b000) begin errors++; $display("FAIL single_idle_grant got %b exp 000", o_grant); end
    checks++; if (bus.s_axis_tx_tvalid !== 1'b0) begin errors++; $display("FAIL single_idle_tvalid got %b exp 0", bus.s_axis_tx_tvalid); end
  endtask

  task automatic test_round_robin();
    int owner;
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) load(k, 2, 1);
    drive_src();
    for (int p = 0; p < 4; p++) begin
      owner = p % 3;
      tick();
      checks++; if (o_grant !== 3'(1 << owner)) begin errors++; $display("FAIL rr_grant pkt %0d got %b exp %b", p, o_grant, 3'(1 << owner)); end
      checks++; if (bus.s_axis_tx_tdata !== exp_data(owner, p / 3, 0)) begin errors++; $display("FAIL rr_data0 pkt %0d got %h exp %h", p, bus.s_axis_tx_tdata, exp_data(owner, p / 3, 0)); end
      tick();
      checks++; if (bus.s_axis_tx_tdata !== exp_data(owner, p / 3, 1) || bus.s_axis_tx_tlast !== 1'b1) begin errors++; $display("FAIL rr_data1 pkt %0d got %h/%b exp %h/1", p, bus.s_axis_tx_tdata, bus.s_axis_tx_tlast, exp_data(owner, p / 3, 1)); end
      tick();
      checks++; if (o_grant !== 3'b000) begin errors++; $display("FAIL rr_gap pkt %0d got %b exp 000", p, o_grant); end
    end
  endtask

  task automatic test_buf_av();
    do_reset();
    tx_buf_av = 6'd1;
    load(1, 2, 0);
    drive_src();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (o_grant !== 3'b000) begin errors++; $display("FAIL bufav_wait cyc %0d got %b exp 000", i, o_grant); end
    end
    tx_buf_av = 6'd2;
    #1;
    tick();
    checks++; if (o_grant !== 3'b010) begin errors++; $display("FAIL bufav_grant got %b exp 010", o_grant); end
    checks++; if (bus.s_axis_tx_tdata !== exp_data(1, 0, 0)) begin errors++; $display("FAIL bufav_data got %h exp %h", bus.s_axis_tx_tdata, exp_data(1, 0, 0)); end
    tick();
    tick();
    checks++; if (o_grant !== 3'b000) begin errors++; $display("FAIL bufav_done got %b exp 000", o_grant); end
  endtask

  task automatic test_cfg();
    do_reset();
    load(0, 4, 0);
    load(1, 2, 0);
    load(2, 2, 0);
    drive_src();
    tick();
    tick();
    tx_cfg_req = 1'b1;
    #1;
    checks++; if (tx_cfg_gnt !== 1'b0 || o_grant !== 3'b001) begin errors++; $display("FAIL cfg_beat1 got gnt %b grant %b exp 0/001", tx_cfg_gnt, o_grant); end
    tick();
    checks++; if (tx_cfg_gnt !== 1'b0) begin errors++; $display("FAIL cfg_beat2 got %b exp 0", tx_cfg_gnt); end
    tick();
    checks++; if (tx_cfg_gnt !== 1'b0 || bus.s_axis_tx_tlast !== 1'b1) begin errors++; $display("FAIL cfg_beat3 got gnt %b tlast %b exp 0/1", tx_cfg_gnt, bus.s_axis_tx_tlast); end
    tick();
    checks++; if (tx_cfg_gnt !== 1'b0 || o_grant !== 3'b000) begin errors++; $display("FAIL cfg_idle got gnt %b grant %b exp 0/000", tx_cfg_gnt, o_grant); end
    tick();
    checks++; if (tx_cfg_gnt !== 1'b1 || sat_cfg_gnt !== 1'b1) begin errors++; $display("FAIL cfg_gnt got %b/%b exp 1/1", tx_cfg_gnt, sat_cfg_gnt); end
    checks++; if (o_grant !== 3'b000 || bus.s_axis_tx_tvalid !== 1'b0 || bus.o_req_tready !== 3'b000) begin errors++; $display("FAIL cfg_port got grant %b tvalid %b tready %b exp 000/0/000", o_grant, bus.s_axis_tx_tvalid, bus.o_req_tready); end
    tick();
    checks++; if (tx_cfg_gnt !== 1'b1) begin errors++; $display("FAIL cfg_hold got %b exp 1", tx_cfg_gnt); end
    tx_cfg_req = 1'b0;
    #1;
    tick();
    checks++; if (tx_cfg_gnt !== 1'b0 || o_grant !== 3'b000) begin errors++; $display("FAIL cfg_release got gnt %b grant %b exp 0/000", tx_cfg_gnt, o_grant); end
    tick();
    checks++; if (o_grant !== 3'b010) begin errors++; $display("FAIL cfg_resume got %b exp 010", o_grant); end
  endtask

  task automatic test_link_loss();
    do_reset();
    load(0, 4, 0);
    load(1, 2, 0);
    drive_src();
    tick();
    tick();
    user_lnk_up = 1'b0;
    #1;
    checks++; if (o_abort !== 1'b0) begin errors++; $display("FAIL link_pre_abort got %b exp 0", o_abort); end
    tick();
    checks++; if (o_abort !== 1'b1) begin errors++; $display("FAIL link_abort got %b exp 1", o_abort); end
    checks++; if (o_grant !== 3'b000 || bus.s_axis_tx_tvalid !== 1'b0 || bus.o_req_tready !== 3'b000) begin errors++; $display("FAIL link_port got grant %b tvalid %b tready %b exp 000/0/000", o_grant, bus.s_axis_tx_tvalid, bus.o_req_tready); end
    tick();
    checks++; if (o_abort !== 1'b0 || o_grant !== 3'b000) begin errors++; $display("FAIL link_down got abort %b grant %b exp 0/000", o_abort, o_grant); end
    user_lnk_up = 1'b1;
    #1;
    tick();
    checks++; if (o_grant !== 3'b010) begin errors++; $display("FAIL link_resume got %b exp 010", o_grant); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load(0, 4, 0);
    drive_src();
    tick();
    checks++; if (o_grant !== 3'b001) begin errors++; $display("FAIL rstmid_start got %b exp 001", o_grant); end
    rst_n = 1'b0;
    #1;
    tick();
    checks++; if (o_grant !== 3'b000 || o_abort !== 1'b0 || bus.s_axis_tx_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid got grant %b abort %b tvalid %b exp 000/0/0", o_grant, o_abort, bus.s_axis_tx_tvalid); end
    rst_n = 1'b1;
  endtask

  task automatic test_drop_count();
    do_reset();
    tx_err_drop = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) tick();
    tx_err_drop = 1'b0;
    #1;
    checks++; if (o_drop_count !== 16'd3) begin errors++; $display("FAIL drop3 got %0d exp 3", o_drop_count); end
    checks++; if (sat_drop_count !== 2'd3) begin errors++; $display("FAIL drop3_sat got %0d exp 3", sat_drop_count); end
    tick();
    checks++; if (o_drop_count !== 16'd3) begin errors++; $display("FAIL drop_hold got %0d exp 3", o_drop_count); end
    tx_err_drop = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) tick();
    tx_err_drop = 1'b0;
    #1;
    checks++; if (o_drop_count !== 16'd8) begin errors++; $display("FAIL drop8 got %0d exp 8", o_drop_count); end
    checks++; if (sat_drop_count !== 2'd3) begin errors++; $display("FAIL drop_sat got %0d exp 3", sat_drop_count); end
  endtask

  initial begin
    bus_sat.i_req_tdata      = '0;
    bus_sat.i_req_tkeep      = '0;
    bus_sat.i_req_tuser      = '0;
    bus_sat.i_req_tlast      = '0;
    bus_sat.i_req_tvalid     = '0;
    bus_sat.s_axis_tx_tready = 1'b1;

    test_reset();
    test_single();
    test_round_robin();
    test_buf_av();
    test_cfg();
    test_link_loss();
    test_reset_mid();
    test_drop_count();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
